// File: rtl/bsg_two_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_two_fifo_pkg
//  Description : Shared constants and types for the two-entry negedge-feed
//                buffer: entry count, occupancy counter width, count type.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_two_fifo_pkg;

    // Number of storage entries in the buffer.
    localparam int els_lp = 2;

    // Occupancy counter must encode 0..els_lp inclusive.
    localparam int count_width_lp = $clog2(els_lp + 1);

    typedef logic [count_width_lp-1:0] count_t;

    localparam count_t c_count_empty = count_t'(0);
    localparam count_t c_count_full  = count_t'(els_lp);

endpackage : bsg_two_fifo_pkg
`default_nettype wire

// File: rtl/bsg_two_fifo_negedge_feed_if.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_two_fifo_negedge_feed_if
//  Description : Handshake bundle for the two-entry negedge-feed buffer.
//                Producer side : data_i, v_i, ready_o
//                Consumer side : data_o, v_o, yumi_i
//                Debug/flow    : count_o
//                Modport slave  - the buffer itself.
//                Modport master - the surrounding producer/consumer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bsg_two_fifo_negedge_feed_if
    import bsg_two_fifo_pkg::*;
#(
    parameter int width_p = -1
);

    logic [width_p-1:0] data_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               yumi_i;
    count_t             count_o;

    modport slave (
        input  data_i,
        input  v_i,
        output ready_o,
        output data_o,
        output v_o,
        input  yumi_i,
        output count_o
    );

    modport master (
        output data_i,
        output v_i,
        input  ready_o,
        input  data_o,
        input  v_o,
        output yumi_i,
        input  count_o
    );

endinterface : bsg_two_fifo_negedge_feed_if
`default_nettype wire

// File: rtl/bsg_two_fifo_negedge_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_two_fifo_negedge_out_reg
//  Description : Falling-edge launch register for the buffer head
//                (valid + data). Synchronous active-low reset sampled on the
//                falling edge clears the whole word.
//  Ports       : clk_i      - clock (captures on negedge)
//                reset_n_i  - synchronous active-low reset
//                d_i        - {valid, data} to launch
//                q_o        - registered {valid, data}
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_two_fifo_negedge_out_reg #(
    parameter int width_p = -1
) (
    input  wire logic               clk_i,
    input  wire logic               reset_n_i,
    input  wire logic [width_p:0]   d_i,
    output      logic [width_p:0]   q_o
);

    logic [width_p:0] r_q;

    always_ff @(negedge clk_i) begin
        if (!reset_n_i) begin
            r_q <= '0;
        end else begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule : bsg_two_fifo_negedge_out_reg
`default_nettype wire

// File: rtl/bsg_two_fifo_negedge_feed.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_two_fifo_negedge_feed
//  Description : Two-entry ready/valid buffer feeding a downstream
//                negedge-capture stage at full throughput (1 word/cycle).
//  Ports       : clk_i      - single clock, state updates on posedge
//                reset_n_i  - synchronous active-low reset
//                fifo_if    - slave modport: data_i/v_i/ready_o (producer),
//                             data_o/v_o/yumi_i (consumer), count_o (0..2)
//  Options     : BSG_TWO_FIFO_NEGEDGE_LAUNCH_EN - when defined, v_o/data_o
//                are relaunched from a negedge register half a cycle after
//                each posedge; otherwise they are combinational from the
//                head entry. ready_o/count_o are identical in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_two_fifo_negedge_feed
    import bsg_two_fifo_pkg::*;
#(
    parameter int width_p = -1
) (
    input  wire logic                 clk_i,
    input  wire logic                 reset_n_i,
    bsg_two_fifo_negedge_feed_if.slave fifo_if
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [width_p-1:0] r_mem [els_lp];
    logic               r_rptr;
    logic               r_wptr;
    count_t             r_count;
    logic [width_p-1:0] r_last_data;   // head value last dequeued

    logic               w_ready;
    logic               w_not_empty;
    logic               w_enq;
    logic               w_deq;
    logic               w_head_v;
    logic [width_p-1:0] w_head_data;

    // ready depends only on registered occupancy: no path from yumi_i.
    assign w_ready     = (r_count != c_count_full);
    assign w_not_empty = (r_count != c_count_empty);

    assign w_enq = fifo_if.v_i & w_ready;
    // A dequeue request against an empty buffer is dropped.
    assign w_deq = fifo_if.yumi_i & w_not_empty;

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= fifo_if.data_i;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and last-head hold register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rptr      <= 1'b0;
            r_wptr      <= 1'b0;
            r_count     <= c_count_empty;
            r_last_data <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr      <= ~r_rptr;
                r_last_data <= r_mem[r_rptr];
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + count_t'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - count_t'(1);
            end
        end
    end

    // While empty, the head slot holds stale or unwritten data, so the
    // output shows the last word handed over (zero after reset) instead.
    assign w_head_v    = w_not_empty;
    assign w_head_data = w_not_empty ? r_mem[r_rptr] : r_last_data;

    // ------------------------------------------------------------------
    // Output launch
    // ------------------------------------------------------------------
`ifdef BSG_TWO_FIFO_NEGEDGE_LAUNCH_EN
    logic [width_p:0] w_out_q;

    bsg_two_fifo_negedge_out_reg #(
        .width_p (width_p)
    ) u_out_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       ({w_head_v, w_head_data}),
        .q_o       (w_out_q)
    );

    assign fifo_if.v_o    = w_out_q[width_p];
    assign fifo_if.data_o = w_out_q[width_p-1:0];
`else
    assign fifo_if.v_o    = w_head_v;
    assign fifo_if.data_o = w_head_data;
`endif

    assign fifo_if.ready_o = w_ready;
    assign fifo_if.count_o = r_count;

    // Consumer must not dequeue from an empty buffer.
    a_no_yumi_when_empty : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        fifo_if.yumi_i |-> w_not_empty
    );

endmodule : bsg_two_fifo_negedge_feed
`default_nettype wire

// File: tb/tb_bsg_two_fifo_negedge_feed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_two_fifo_negedge_feed
//  Description : Directed self-checking bench for bsg_two_fifo_negedge_feed.
//                Outputs are sampled 1 time unit after each falling edge,
//                which is after the posedge update in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_two_fifo_negedge_feed;
    import bsg_two_fifo_pkg::*;

    localparam int c_width = 8;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    logic mon_en;

    bsg_two_fifo_negedge_feed_if #(.width_p(c_width)) fifo_if ();

    bsg_two_fifo_negedge_feed #(
        .width_p (c_width)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .fifo_if   (fifo_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

`ifdef BSG_TWO_FIFO_NEGEDGE_LAUNCH_EN
    // Launched outputs must only move while clk is low (falling-edge launch).
    always @(fifo_if.data_o or fifo_if.v_o) begin
        if (mon_en) begin
            vectors++;
            if (clk !== 1'b0) begin
                miscompares++;
                $display("FAIL edge_align: output changed with clk=%b at t=%0t, required clk=0", clk, $time);
            end
        end
    end
`endif

    task automatic test_reset;
        reset_n        = 1'b0;
        fifo_if.v_i    = 1'b1;
        fifo_if.data_i = 8'hA5;
        fifo_if.yumi_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (fifo_if.v_o !== 1'b0) begin miscompares++; $display("FAIL reset_v: got %b want 0", fifo_if.v_o); end
        vectors++;
        if (fifo_if.ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", fifo_if.ready_o); end
        vectors++;
        if (fifo_if.count_o !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_if.count_o); end
        vectors++;
        if (fifo_if.data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", fifo_if.data_o); end
        reset_n     = 1'b1;
        fifo_if.v_i = 1'b0;
        tick();
        vectors++;
        if (fifo_if.count_o !== 2'd0 || fifo_if.v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_write: count=%0d v=%b want count=0 v=0", fifo_if.count_o, fifo_if.v_o);
        end
    endtask

    task automatic test_fill;
        fifo_if.v_i    = 1'b1;
        fifo_if.data_i = 8'h11;
        tick();
        vectors++;
        if (fifo_if.count_o !== 2'd1 || fifo_if.v_o !== 1'b1 || fifo_if.data_o !== 8'h11 || fifo_if.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_first: count=%0d v=%b data=%h ready=%b want 1 1 11 1",
                     fifo_if.count_o, fifo_if.v_o, fifo_if.data_o, fifo_if.ready_o);
        end
        fifo_if.data_i = 8'h22;
        tick();
        vectors++;
        if (fifo_if.count_o !== 2'd2 || fifo_if.ready_o !== 1'b0 || fifo_if.data_o !== 8'h11) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d ready=%b data=%h want 2 0 11",
                     fifo_if.count_o, fifo_if.ready_o, fifo_if.data_o);
        end
        fifo_if.data_i = 8'h33;
        tick();
        vectors++;
        if (fifo_if.count_o !== 2'd2 || fifo_if.data_o !== 8'h11 || fifo_if.v_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drop: count=%0d data=%h v=%b want 2 11 1",
                     fifo_if.count_o, fifo_if.data_o, fifo_if.v_o);
        end
        fifo_if.v_i = 1'b0;
    endtask

    // Starts from the full state left by test_fill.
    task automatic test_drain;
        fifo_if.yumi_i = 1'b1;
        tick();
        vectors++;
        if (fifo_if.data_o !== 8'h22 || fifo_if.count_o !== 2'd1 || fifo_if.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_second: data=%h count=%0d ready=%b want 22 1 1",
                     fifo_if.data_o, fifo_if.count_o, fifo_if.ready_o);
        end
        tick();
        fifo_if.yumi_i = 1'b0;
        vectors++;
        if (fifo_if.v_o !== 1'b0 || fifo_if.count_o !== 2'd0 || fifo_if.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_empty: v=%b count=%0d ready=%b want 0 0 1",
                     fifo_if.v_o, fifo_if.count_o, fifo_if.ready_o);
        end
        vectors++;
        if (fifo_if.data_o !== 8'h22) begin
            miscompares++;
            $display("FAIL drain_hold: data=%h want 22", fifo_if.data_o);
        end
    endtask

    task automatic test_streaming;
        mon_en         = 1'b1;
        fifo_if.v_i    = 1'b1;
        fifo_if.data_i = 8'd1;
        fifo_if.yumi_i = 1'b0;
        tick();
        vectors++;
        if (fifo_if.v_o !== 1'b1 || fifo_if.data_o !== 8'd1 || fifo_if.count_o !== 2'd1) begin
            miscompares++;
            $display("FAIL stream_first: v=%b data=%h count=%0d want 1 01 1",
                     fifo_if.v_o, fifo_if.data_o, fifo_if.count_o);
        end
        for (int k = 2; k <= 20; k++) begin
            fifo_if.data_i = 8'(k);
            fifo_if.yumi_i = 1'b1;
            tick();
            vectors++;
            if (fifo_if.v_o !== 1'b1 || fifo_if.data_o !== 8'(k) || fifo_if.count_o !== 2'd1) begin
                miscompares++;
                $display("FAIL stream_word: k=%0d v=%b data=%h count=%0d want 1 %h 1",
                         k, fifo_if.v_o, fifo_if.data_o, fifo_if.count_o, 8'(k));
            end
        end
        fifo_if.v_i = 1'b0;
        tick();
        fifo_if.yumi_i = 1'b0;
        vectors++;
        if (fifo_if.v_o !== 1'b0 || fifo_if.count_o !== 2'd0 || fifo_if.data_o !== 8'd20) begin
            miscompares++;
            $display("FAIL stream_end: v=%b count=%0d data=%h want 0 0 14",
                     fifo_if.v_o, fifo_if.count_o, fifo_if.data_o);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        fifo_if.v_i    = 1'b1;
        fifo_if.data_i = 8'h11;
        tick();
        fifo_if.data_i = 8'h22;
        tick();
        vectors++;
        if (fifo_if.count_o !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_full: count=%0d want 2", fifo_if.count_o);
        end
        reset_n        = 1'b0;
        fifo_if.yumi_i = 1'b1;
        tick();
        reset_n        = 1'b1;
        fifo_if.v_i    = 1'b0;
        fifo_if.yumi_i = 1'b0;
        vectors++;
        if (fifo_if.count_o !== 2'd0 || fifo_if.v_o !== 1'b0 || fifo_if.ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: count=%0d v=%b ready=%b want 0 0 1",
                     fifo_if.count_o, fifo_if.v_o, fifo_if.ready_o);
        end
        fifo_if.v_i    = 1'b1;
        fifo_if.data_i = 8'h44;
        tick();
        fifo_if.v_i = 1'b0;
        vectors++;
        if (fifo_if.v_o !== 1'b1 || fifo_if.data_o !== 8'h44 || fifo_if.count_o !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_after: v=%b data=%h count=%0d want 1 44 1",
                     fifo_if.v_o, fifo_if.data_o, fifo_if.count_o);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        mon_en         = 1'b0;
        reset_n        = 1'b0;
        fifo_if.v_i    = 1'b0;
        fifo_if.data_i = '0;
        fifo_if.yumi_i = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bsg_two_fifo_negedge_feed
`default_nettype wire

// File: doc/bsg_two_fifo_negedge_feed.md
Name: bsg_two_fifo_negedge_feed

Overview:
- 2-entry ready/valid buffer that feeds a downstream negedge-capture register stage.
- Decouples a posedge producer from a half-cycle consumer and sustains full throughput (1 word/cycle).
- Holds data stable across the falling edge so downstream negedge flops capture a clean value.
- Tracks occupancy for debug and for flow-control.

Parameters:
- width_p, -1 (must be overridden; ≥1): data width in bits.
- count_width_lp, 2 (localparam, fixed): occupancy counter width, encodes 0..2.

Ports:
- clk_i  in  1  single clock; all state updates on posedge unless stated otherwise.
- reset_n_i  in  1  reset; synchronous, active-low.
- data_i  in  width_p  producer data.
- v_i  in  1  producer valid.
- ready_o  out  1  buffer can accept; transfer occurs when v_i & ready_o at posedge.
- data_o  out  width_p  head-of-buffer data, to downstream negedge stage.
- v_o  out  1  head valid.
- yumi_i  in  1  consumer dequeue; legal only when v_o=1.
- count_o  out  count_width_lp  entries held, 0..2.

Behaviour:
- Storage: two entries mem[0..1], read pointer rptr_r, write pointer wptr_r, occupancy count_r.
- Reset (reset_n_i=0 at posedge): rptr_r=0, wptr_r=0, count_r=0. Outputs: v_o=0, ready_o=1, count_o=0, data_o=0. Memory contents are not reset.
- ready_o = (count_r != 2). This depends on registered state only, with no combinational path from yumi_i.
- Enqueue (v_i & ready_o at posedge): mem[wptr_r] <= data_i; wptr_r toggles.
- Dequeue (yumi_i at posedge): rptr_r toggles.
- Count update: count_r +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Simultaneous enqueue+dequeue:
  - count=1: count stays 1; the newly written word becomes head on the next cycle.
  - count=2: enqueue is impossible because ready_o=0.
- Full (count=2): ready_o=0. v_i is ignored and data_i is not written.
- Empty (count=0): v_o=0 and data_o holds its last value.
- Latency, macro off: a word enqueued at posedge N appears on v_o/data_o just after posedge N (1-cycle latency).
- yumi_i while v_o=0: illegal. Assertion fires; state is unchanged (dequeue suppressed).
- Reset mid-operation: all entries are discarded. The next cycle shows v_o=0 regardless of yumi_i or v_i.
- Pointers are 1 bit and wrap naturally 1→0.

Optional Feature:
- Macro: BSG_TWO_FIFO_NEGEDGE_LAUNCH_EN.
- Defined:
  - v_o/data_o are driven from an internal output register clocked on negedge clk_i.
  - That register loads head valid/data computed from post-posedge state.
  - Synchronous active-low reset is sampled at negedge: v_o=0, data_o=0.
  - Outputs change half a cycle after posedge N.
  - Consumer has the remaining half cycle to form yumi_i for posedge N+1.
  - Throughput is unchanged.
- Undefined: v_o/data_o are combinational from mem[rptr_r] and (count_r != 0).
- Both builds: ready_o and count_o are identical and always posedge-derived.

Decomposition:
- Shared package bsg_two_fifo_pkg:
  - constant for the entry count (2);
  - count_width_lp derivation;
  - typedef for the count type.
- One natural sub-module: bsg_two_fifo_negedge_out_reg.
  - Negedge, sync active-low reset, width_p+1 register (valid+data).
  - Instantiated only under the macro.
- All remaining logic lives in the top module.

Test Plan:
- Reset: hold reset_n_i=0 for 2 cycles with v_i=1, data_i=0xA5 → v_o=0, ready_o=1, count_o=0. No write persists after release.
- Fill: enqueue 0x11 then 0x22 with yumi_i=0.
  - count_o goes 1 then 2; ready_o=0 after the second write.
  - v_i=1 with data 0x33 is dropped.
  - data_o=0x11.
- Streaming: v_i=1 and yumi_i=1 every cycle with data 1,2,3,…,20 → data_o emits 1..20 in order, count_o stays 1, no bubbles after the first word.
- Drain: from full (0x11, 0x22), yumi_i for 2 cycles → data_o 0x11 then 0x22, then v_o=0, count_o=0, ready_o=1.
- Reset mid-stream: at count=2, pulse reset_n_i=0 for one posedge → next cycle count_o=0, v_o=0. A subsequent enqueue of 0x44 emerges as data_o=0x44.
- Macro build: repeat the streaming test with BSG_TWO_FIFO_NEGEDGE_LAUNCH_EN defined.
  - Check v_o/data_o transition only at negedges.
  - A negedge-capture register sampling data_o records 1..20 without loss.
